answer_countdown_display: RTL

// - Answer-time countdown plus final 8-digit tube output stage; sits directly downstream of the

---
 rtl/tube_pkg.sv | 29 ++
 rtl/tick_gen.sv | 38 +++
 rtl/answer_countdown_display.sv | 136 +++++++++++++
 3 files changed

// File: rtl/tube_pkg.sv
// Shared constants for the 8-digit tube output stage: segment codes, enables, FSM states.
package tube_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] EN_NONE   = 8'hFF;
  localparam logic [7:0] EN_ONES   = 8'hFE;
  localparam logic [7:0] EN_TENS   = 8'hFD;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is off in every entry.
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    seg_of = (d <= 4'd9) ? SEG_DIGIT[d] : SEG_BLANK;
  endfunction

  function automatic logic [7:0] to_bcd(input int unsigned v);
    to_bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-cycle pulse every DIV enabled cycles; counter held at zero while disabled or cleared.
module tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == LAST);
  assign tick = en && !clr && wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/answer_countdown_display.sv
// Answer-time countdown with BCD seconds display, timeout blink and idle animation passthrough.
module answer_countdown_display
  import tube_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned SCAN_DIV  = 100_000,
  parameter int unsigned BLINK_DIV = 50_000_000,
  parameter int unsigned START_SEC = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] buf_seg_out,
  input  logic [7:0] buf_seg_en,
  output logic [7:0] seg_out,
  output logic [7:0] seg_en,
  output logic       busy,
  output logic       timeout
);

  localparam logic [7:0] START_BCD = to_bcd(START_SEC);

  state_e     state_q, state_d;
  logic [3:0] tens_q, tens_d, ones_q, ones_d;
  logic       scan_ph_q, scan_ph_d, blink_ph_q, blink_ph_d;
  logic [7:0] seg_out_q, seg_out_d, seg_en_q, seg_en_d;
  logic       busy_q, busy_d, timeout_q, timeout_d;
  logic       sec_tick, scan_tick, blink_tick;

  tick_gen #(.DIV(CLK_HZ)) u_sec (
    .clk(clk), .rst(rst), .en(state_q == ST_COUNT), .clr(start), .tick(sec_tick)
  );
  tick_gen #(.DIV(SCAN_DIV)) u_scan (
    .clk(clk), .rst(rst), .en(state_q != ST_IDLE), .clr(start), .tick(scan_tick)
  );
  tick_gen #(.DIV(BLINK_DIV)) u_blink (
    .clk(clk), .rst(rst), .en(state_q == ST_TIMEOUT), .clr(start), .tick(blink_tick)
  );

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    if (start) begin
      state_d          = ST_COUNT;
      {tens_d, ones_d} = START_BCD;
    end else if (state_q == ST_COUNT) begin
      if (stop) begin
        state_d = ST_HOLD;
      end else if (sec_tick) begin
        if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
        // Leave COUNT on the same tick that reaches 00 so 00 is never shown counting.
        if (tens_q == 4'd0 && ones_q == 4'd1) begin
          state_d = ST_TIMEOUT;
        end
      end
    end
  end

  always_comb begin
    scan_ph_d  = scan_ph_q;
    blink_ph_d = blink_ph_q;
    if (start || state_q == ST_IDLE) begin
      scan_ph_d = 1'b0;
    end else if (scan_tick) begin
      scan_ph_d = ~scan_ph_q;
    end
    if (start || state_q != ST_TIMEOUT) begin
      blink_ph_d = 1'b0;
    end else if (blink_tick) begin
      blink_ph_d = ~blink_ph_q;
    end
  end

  always_comb begin
    seg_out_d = SEG_BLANK;
    seg_en_d  = EN_NONE;
    busy_d    = (state_q == ST_COUNT);
    timeout_d = (state_q == ST_TIMEOUT);
    case (state_q)
      ST_IDLE: begin
        seg_out_d = buf_seg_out;
        seg_en_d  = buf_seg_en;
      end
      ST_TIMEOUT: begin
        seg_out_d = SEG_DIGIT[0];
        seg_en_d  = blink_ph_q ? EN_NONE : (scan_ph_q ? EN_TENS : EN_ONES);
      end
      default: begin
        if (!scan_ph_q) begin
          seg_en_d  = EN_ONES;
          seg_out_d = seg_of(ones_q);
        end else begin
          seg_en_d  = EN_TENS;
          seg_out_d = (tens_q == 4'd0) ? SEG_BLANK : seg_of(tens_q);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      scan_ph_q  <= 1'b0;
      blink_ph_q <= 1'b0;
      seg_out_q  <= SEG_BLANK;
      seg_en_q   <= EN_NONE;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      scan_ph_q  <= scan_ph_d;
      blink_ph_q <= blink_ph_d;
      seg_out_q  <= seg_out_d;
      seg_en_q   <= seg_en_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign seg_out = seg_out_q;
  assign seg_en  = seg_en_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule
